// File: rtl/fall_scan_controller.sv
// Round-robin fall detector: shares one external comparator across NUM_CH sensor channels
// and latches a per-channel alarm after CONFIRM consecutive positive samples.
module fall_scan_controller #(
  parameter int NUM_CH  = 4,
  parameter int CONFIRM = 3,
  parameter int DW      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH*DW-1:0]      sensorValues,
  input  logic [DW-1:0]             factoryValue,
  output logic [DW-1:0]             cmpSensor,
  output logic [DW-1:0]             cmpFactory,
  input  logic                      cmpResult,
  input  logic [NUM_CH-1:0]         alarmAck,
  output logic [NUM_CH-1:0]         alarm,
  output logic                      alarmAny,
  output logic [$clog2(NUM_CH)-1:0] scanCh,
  output logic                      scanDone
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(CONFIRM + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CONFIRM);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL} state_t;

  state_t stateReg, stateNext;
  logic   evalPhase;

  always_ff @(posedge clk) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    evalPhase = 1'b0;
    case (stateReg)
      IDLE: if (enable) stateNext = LOAD;
      LOAD: stateNext = EVAL;
      EVAL: begin
        evalPhase = 1'b1;
        stateNext = enable ? LOAD : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operands are registered in LOAD so the external comparator settles during EVAL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scanCh     <= '0;
      cmpSensor  <= '0;
      cmpFactory <= '0;
      scanDone   <= 1'b0;
    end else begin
      scanDone <= evalPhase && (scanCh == LAST_CH);
      if (stateReg == LOAD) begin
        cmpSensor  <= sensorValues[int'(scanCh)*DW +: DW];
        cmpFactory <= factoryValue;
      end
      if (evalPhase) scanCh <= (scanCh == LAST_CH) ? '0 : scanCh + CHW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : genCh
      logic [CW-1:0] cntReg;
      logic          alarmReg;
      logic          sampled;
      logic          setCond;

      assign sampled = evalPhase && (scanCh == CHW'(gi));
      // cnt+1 >= CONFIRM, written without the carry so it stays CW bits wide
      assign setCond = sampled && cmpResult && (cntReg >= CNT_MAX - CW'(1));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cntReg   <= '0;
          alarmReg <= 1'b0;
        end else if (setCond) begin
          cntReg   <= CNT_MAX;
          alarmReg <= 1'b1;
        end else if (alarmAck[gi]) begin
          cntReg   <= '0;
          alarmReg <= 1'b0;
        end else if (sampled) begin
          cntReg <= cmpResult ? cntReg + CW'(1) : '0;
        end
      end

      assign alarm[gi] = alarmReg;
    end
  endgenerate

  assign alarmAny = |alarm;

endmodule

// File: tb/tb_fall_scan_controller.sv
// Bench for fall_scan_controller: step-level reference model of the scan/confirm/ack rules,
// directed scenarios followed by randomized sweeps.
module tb_fall_scan_controller;
  localparam int NUM_CH  = 4;
  localparam int CONFIRM = 3;
  localparam int DW      = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic [NUM_CH*DW-1:0] sensorValues = '0;
  logic [DW-1:0]        factoryValue = '0;
  logic [DW-1:0]        cmpSensor;
  logic [DW-1:0]        cmpFactory;
  logic                 cmpResult;
  logic [NUM_CH-1:0]    alarmAck = '0;
  logic [NUM_CH-1:0]    alarm;
  logic                 alarmAny;
  logic [1:0]           scanCh;
  logic                 scanDone;

  int nChecks = 0;
  int nFails = 0;
  int cycleCount = 0;

  // reference state: channel sensor values, confirm counts, latched alarms, scan pointer
  int sens[NUM_CH];
  int mCnt[NUM_CH];
  bit mAlarm[NUM_CH];
  int mCh;
  bit mIdle;

  fall_scan_controller #(.NUM_CH(NUM_CH), .CONFIRM(CONFIRM), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensorValues(sensorValues),
    .factoryValue(factoryValue), .cmpSensor(cmpSensor), .cmpFactory(cmpFactory),
    .cmpResult(cmpResult), .alarmAck(alarmAck), .alarm(alarm), .alarmAny(alarmAny),
    .scanCh(scanCh), .scanDone(scanDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  // the shared comparator that lives outside the block
  assign cmpResult = (cmpSensor >= cmpFactory);

  function automatic void apply_sensors();
    for (int i = 0; i < NUM_CH; i++) sensorValues[i*DW +: DW] = DW'(sens[i]);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_alarm();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = mAlarm[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      mCnt[i] = 0;
      mAlarm[i] = 1'b0;
    end
    mCh = 0;
    mIdle = 1'b1;
  endfunction

  // one channel evaluation: positive samples accumulate (capped at CONFIRM), reaching CONFIRM
  // latches the alarm and beats a same-cycle ack; otherwise an ack clears alarm and count
  function automatic void model_step(input int val, input int thr, input logic [NUM_CH-1:0] ack);
    bit pos;
    int nextCnt;
    pos = (val >= thr);
    for (int i = 0; i < NUM_CH; i++) begin
      nextCnt = (mCnt[i] + 1 > CONFIRM) ? CONFIRM : mCnt[i] + 1;
      if (i == mCh && pos && nextCnt >= CONFIRM) begin
        mAlarm[i] = 1'b1;
        mCnt[i] = nextCnt;
      end else if (ack[i]) begin
        mAlarm[i] = 1'b0;
        mCnt[i] = 0;
      end else if (i == mCh) begin
        mCnt[i] = pos ? nextCnt : 0;
      end
    end
    mCh = (mCh + 1) % NUM_CH;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    alarmAck = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One channel scan. Ack is applied only during the EVAL cycle; glitch scrambles the
  // sensor bus after capture; dropEn deasserts enable during LOAD.
  task automatic do_step(input logic [NUM_CH-1:0] ack, input bit dropEn, input bit glitch);
    int ch;
    int capVal;
    int thr;
    logic [NUM_CH-1:0] ea;
    ch = mCh;
    capVal = sens[ch];
    thr = int'(factoryValue);
    if (mIdle) begin
      enable = 1'b1;
      @(posedge clk);
      #1;
    end
    if (dropEn) enable = 1'b0;
    @(posedge clk);
    #1;
    nChecks++;
    if (scanDone !== 1'b0) begin
      nFails++;
      $display("FAIL step_eval_scanDone: ch=%0d got=%b required=0", ch, scanDone);
    end
    nChecks++;
    if ({cmpSensor, cmpFactory} !== {DW'(capVal), DW'(thr)}) begin
      nFails++;
      $display("FAIL step_operands: ch=%0d got=%02h/%02h required=%02h/%02h",
               ch, cmpSensor, cmpFactory, capVal, thr);
    end
    alarmAck = ack;
    if (glitch) begin
      for (int i = 0; i < NUM_CH; i++) sensorValues[i*DW +: DW] = DW'($urandom);
    end
    @(posedge clk);
    #1;
    alarmAck = '0;
    apply_sensors();
    model_step(capVal, thr, ack);
    mIdle = dropEn;
    ea = exp_alarm();
    nChecks++;
    if ({alarm, alarmAny, scanCh, scanDone} !== {ea, |ea, 2'(mCh), ch == NUM_CH - 1}) begin
      nFails++;
      $display("FAIL step_result: ch=%0d got alarm=%b any=%b scanCh=%0d done=%b required alarm=%b any=%b scanCh=%0d done=%b",
               ch, alarm, alarmAny, scanCh, scanDone, ea, |ea, mCh, ch == NUM_CH - 1);
    end
    $display("step ch=%0d val=%02h thr=%02h ack=%b drop=%b alarm=%b scanDone=%b",
             ch, capVal, thr, ack, dropEn, alarm, scanDone);
  endtask

  task automatic test_reset();
    do_reset();
    nChecks++;
    if ({alarm, alarmAny, scanCh, scanDone, cmpSensor, cmpFactory} !== '0) begin
      nFails++;
      $display("FAIL reset_state: got alarm=%b any=%b scanCh=%0d done=%b cmp=%02h/%02h required all zero",
               alarm, alarmAny, scanCh, scanDone, cmpSensor, cmpFactory);
    end
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'hC0;
    factoryValue = 8'h40;
    apply_sensors();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      nChecks++;
      if ({alarm, scanCh, scanDone, cmpSensor, cmpFactory} !== '0) begin
        nFails++;
        $display("FAIL idle_hold: cycle=%0d got alarm=%b scanCh=%0d done=%b cmp=%02h/%02h required all zero",
                 c, alarm, scanCh, scanDone, cmpSensor, cmpFactory);
      end
    end
  endtask

  task automatic test_single_confirm();
    int cBase;
    int lat;
    int lastDone;
    do_reset();
    factoryValue = 8'h80;
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'h10;
    sens[2] = 8'h90;
    apply_sensors();
    cBase = cycleCount;
    lat = -1;
    lastDone = -1;
    for (int s = 0; s < 12; s++) begin
      do_step('0, 1'b0, 1'b0);
      if (alarm[2] === 1'b1 && lat < 0) lat = cycleCount - cBase - 1;
      if (scanDone === 1'b1) begin
        if (lastDone >= 0) begin
          nChecks++;
          if (cycleCount - lastDone != 2 * NUM_CH) begin
            nFails++;
            $display("FAIL scanDone_period: got=%0d required=%0d", cycleCount - lastDone, 2 * NUM_CH);
          end
        end
        lastDone = cycleCount;
      end
    end
    nChecks++;
    if (lat != 22) begin
      nFails++;
      $display("FAIL confirm_latency: got=%0d cycles required=22", lat);
    end
    nChecks++;
    if ({alarm, alarmAny} !== {4'b0100, 1'b1}) begin
      nFails++;
      $display("FAIL single_alarm: got alarm=%b any=%b required 0100/1", alarm, alarmAny);
    end
  endtask

  task automatic test_glitch();
    bit high;
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'h10;
    apply_sensors();
    do_step('1, 1'b0, 1'b0);
    high = 1'b1;
    for (int s = 0; s < 10 * NUM_CH; s++) begin
      if (mCh == 1) begin
        sens[1] = high ? 8'h90 : 8'h10;
        high = ~high;
        apply_sensors();
      end
      do_step('0, 1'b0, 1'b1);
    end
    nChecks++;
    if (alarm[1] !== 1'b0) begin
      nFails++;
      $display("FAIL glitch_reject: got alarm[1]=%b required=0", alarm[1]);
    end
  endtask

  task automatic test_equality();
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'h10;
    sens[0] = 8'h80;
    factoryValue = 8'h80;
    apply_sensors();
    do_step('1, 1'b0, 1'b0);
    for (int s = 0; s < 3 * NUM_CH; s++) do_step('0, 1'b0, 1'b0);
    nChecks++;
    if (alarm[0] !== 1'b1) begin
      nFails++;
      $display("FAIL equality_positive: got alarm[0]=%b required=1", alarm[0]);
    end
    sens[0] = 8'h7F;
    apply_sensors();
    do_step('1, 1'b0, 1'b0);
    for (int s = 0; s < 3 * NUM_CH; s++) do_step('0, 1'b0, 1'b0);
    nChecks++;
    if (alarm[0] !== 1'b0) begin
      nFails++;
      $display("FAIL below_threshold: got alarm[0]=%b required=0", alarm[0]);
    end
  endtask

  task automatic test_ack_collision();
    bit collided;
    logic [NUM_CH-1:0] ack;
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'h10;
    sens[2] = 8'h90;
    factoryValue = 8'h80;
    apply_sensors();
    do_step('1, 1'b0, 1'b0);
    collided = 1'b0;
    for (int s = 0; s < 4 * NUM_CH && !collided; s++) begin
      collided = (mCh == 2 && mCnt[2] == CONFIRM - 1);
      ack = collided ? 4'b0100 : 4'b0000;
      do_step(ack, 1'b0, 1'b0);
    end
    nChecks++;
    if (!collided || alarm[2] !== 1'b1) begin
      nFails++;
      $display("FAIL ack_set_collision: reached=%0d got alarm[2]=%b required 1/1", collided, alarm[2]);
    end
    sens[2] = 8'h10;
    apply_sensors();
    do_step(4'b0100, 1'b0, 1'b0);
    nChecks++;
    if (alarm[2] !== 1'b0) begin
      nFails++;
      $display("FAIL ack_clear: got alarm[2]=%b required=0", alarm[2]);
    end
    sens[2] = 8'h90;
    apply_sensors();
    for (int s = 0; s < 2 * NUM_CH; s++) do_step('0, 1'b0, 1'b0);
    nChecks++;
    if (alarm[2] !== 1'b0) begin
      nFails++;
      $display("FAIL ack_count_cleared: got alarm[2]=%b required=0", alarm[2]);
    end
  endtask

  task automatic test_enable_drop();
    logic [NUM_CH-1:0] ea;
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'h20 + i;
    factoryValue = 8'h80;
    apply_sensors();
    for (int s = 0; s < NUM_CH && mCh != 1; s++) do_step('0, 1'b0, 1'b0);
    do_step('0, 1'b1, 1'b0);
    ea = exp_alarm();
    sens[1] = 8'hEE;
    apply_sensors();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      nChecks++;
      if ({scanCh, scanDone, alarm, cmpSensor} !== {2'd2, 1'b0, ea, 8'h21}) begin
        nFails++;
        $display("FAIL enable_drop_idle: cycle=%0d got scanCh=%0d done=%b alarm=%b cmpSensor=%02h required 2/0/%b/21",
                 c, scanCh, scanDone, alarm, cmpSensor, ea);
      end
    end
    sens[2] = 8'hA5;
    apply_sensors();
    do_step('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NUM_CH; i++) sens[i] = 8'hFF;
    factoryValue = 8'h80;
    apply_sensors();
    for (int s = 0; s < 3 * NUM_CH; s++) do_step('0, 1'b0, 1'b0);
    if (mIdle) begin
      enable = 1'b1;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    nChecks++;
    if ({alarm, alarmAny, scanCh, scanDone, cmpSensor, cmpFactory} !== '0) begin
      nFails++;
      $display("FAIL reset_mid_sweep: got alarm=%b any=%b scanCh=%0d done=%b cmp=%02h/%02h required all zero",
               alarm, alarmAny, scanCh, scanDone, cmpSensor, cmpFactory);
    end
    rst_n = 1'b1;
    enable = 1'b0;
    model_clear();
    for (int s = 0; s < 2 * NUM_CH; s++) do_step('0, 1'b0, 1'b0);
    nChecks++;
    if (alarm !== '0) begin
      nFails++;
      $display("FAIL reset_counts_cleared: got alarm=%b required=0000", alarm);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] ack;
    do_reset();
    factoryValue = 8'h80;
    for (int i = 0; i < NUM_CH; i++) sens[i] = $urandom_range(8'h60, 8'hC0);
    apply_sensors();
    for (int s = 0; s < 300; s++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 3) == 0) sens[i] = $urandom_range(8'h60, 8'hC0);
      if ($urandom_range(0, 15) == 0) factoryValue = DW'($urandom_range(8'h70, 8'h90));
      apply_sensors();
      for (int i = 0; i < NUM_CH; i++) ack[i] = ($urandom_range(0, 7) == 0);
      do_step(ack, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_confirm();
    test_glitch();
    test_equality();
    test_ack_collision();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
